// File: rtl/alu_pkg.sv
// Shared opcode map, flag-write classes and FSM encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_CMPZ = 4'hC;
  localparam logic [3:0] OP_PASS = 4'hD;

  localparam logic [2:0] W_RF_NONE = 3'b000;
  localparam logic [2:0] W_RF_Z    = 3'b001;
  localparam logic [2:0] W_RF_SZ   = 3'b010;
  localparam logic [2:0] W_RF_SCZ  = 3'b011;
  localparam logic [2:0] W_RF_ALL  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  function automatic logic [2:0] op_to_wrf(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: return W_RF_ALL;
      OP_AND, OP_OR, OP_XOR, OP_NOT:  return W_RF_SZ;
      OP_SLL, OP_SRL, OP_SRA:         return W_RF_SCZ;
      OP_MUL:                         return W_RF_SZ;
      OP_CMPZ:                        return W_RF_Z;
      default:                        return W_RF_NONE;
    endcase
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle logic/arithmetic ops with carry and overflow; undefined ops pass a through.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             carry
);

  logic             is_sub_s;
  logic             is_arith_s;
  logic [WIDTH-1:0] opnd_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH:0]   sum_s;

  // Shared WIDTH+1 adder: subtraction is a + ~b + 1, INC/DEC use an operand of one
  always_comb begin
    is_sub_s   = 1'b0;
    is_arith_s = 1'b1;
    opnd_s     = b;
    case (op)
      OP_ADD: begin is_sub_s = 1'b0; opnd_s = b; end
      OP_SUB: begin is_sub_s = 1'b1; opnd_s = b; end
      OP_INC: begin is_sub_s = 1'b0; opnd_s = WIDTH'(1); end
      OP_DEC: begin is_sub_s = 1'b1; opnd_s = WIDTH'(1); end
      default: begin is_sub_s = 1'b0; is_arith_s = 1'b0; opnd_s = b; end
    endcase
    if (is_sub_s) begin
      addend_s = ~opnd_s;
    end else begin
      addend_s = opnd_s;
    end
    sum_s = {1'b0, a} + {1'b0, addend_s} + {{WIDTH{1'b0}}, is_sub_s};
  end

  // Result mux and raw C/O; non-arithmetic ops report C=0 and O=0
  always_comb begin
    res   = a;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      default: res = a;
    endcase
    if (is_arith_s) begin
      res   = sum_s[WIDTH-1:0];
      carry = sum_s[WIDTH];
      if (is_sub_s) begin
        ovf = (a[WIDTH-1] != opnd_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end else begin
        ovf = (a[WIDTH-1] == opnd_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
    end else begin
      carry = 1'b0;
      ovf   = 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: start/done handshake around single-cycle ops, bit-serial shifts and shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             out_O,
  output logic             out_S,
  output logic             out_C,
  output logic             out_Z,
  output logic [2:0]       w_rf
);

  state_t           state_r;
  logic [3:0]       op_r;
  logic [2:0]       wrf_r;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic             c_r;
  logic             o_r;

  logic [WIDTH-1:0] comb_res_s;
  logic             comb_o_s;
  logic             comb_c_s;
  logic [SHW-1:0]   amt_s;
  logic [WIDTH:0]   first_step_s;
  logic [WIDTH:0]   next_step_s;

  // Returns {bit shifted out, shifted value} for one single-bit shift step
  function automatic logic [WIDTH:0] shift_step(input logic [3:0] sop, input logic [WIDTH-1:0] v);
    case (sop)
      OP_SLL:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_SRA:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: return {v[0], 1'b0, v[WIDTH-1:1]};
    endcase
  endfunction

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op    (op),
    .a     (a),
    .b     (b),
    .res   (comb_res_s),
    .ovf   (comb_o_s),
    .carry (comb_c_s)
  );

  assign amt_s        = b[SHW-1:0];
  assign first_step_s = shift_step(op, a);
  assign next_step_s  = shift_step(op_r, acc_r);

  // Control FSM and datapath; the first shift/multiply step happens on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      result   <= {WIDTH{1'b0}};
      out_O    <= 1'b0;
      out_S    <= 1'b0;
      out_C    <= 1'b0;
      out_Z    <= 1'b0;
      w_rf     <= W_RF_NONE;
      op_r     <= OP_PASS;
      wrf_r    <= W_RF_NONE;
      cnt_r    <= {SHW{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      c_r      <= 1'b0;
      o_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ready <= 1'b0;
            op_r  <= op;
            wrf_r <= op_to_wrf(op);
            if (is_shift(op)) begin
              o_r <= 1'b0;
              if (amt_s == {SHW{1'b0}}) begin
                acc_r   <= a;
                c_r     <= 1'b0;
                state_r <= ST_FIN;
              end else begin
                {c_r, acc_r} <= first_step_s;
                cnt_r        <= amt_s - SHW'(1);
                state_r      <= (amt_s == SHW'(1)) ? ST_FIN : ST_SHIFT;
              end
            end else if (op == OP_MUL) begin
              acc_r    <= a[0] ? b : {WIDTH{1'b0}};
              mcand_r  <= {1'b0, a[WIDTH-1:1]};
              mplier_r <= {b[WIDTH-2:0], 1'b0};
              cnt_r    <= SHW'(WIDTH - 1);
              c_r      <= 1'b0;
              o_r      <= 1'b0;
              state_r  <= ST_MUL;
            end else begin
              acc_r   <= comb_res_s;
              c_r     <= comb_c_s;
              o_r     <= comb_o_s;
              state_r <= ST_FIN;
            end
          end
        end
        ST_SHIFT: begin
          {c_r, acc_r} <= next_step_s;
          cnt_r        <= cnt_r - SHW'(1);
          if (cnt_r == SHW'(1)) begin
            state_r <= ST_FIN;
          end
        end
        ST_MUL: begin
          acc_r    <= acc_r + (mcand_r[0] ? mplier_r : {WIDTH{1'b0}});
          mcand_r  <= {1'b0, mcand_r[WIDTH-1:1]};
          mplier_r <= {mplier_r[WIDTH-2:0], 1'b0};
          cnt_r    <= cnt_r - SHW'(1);
          if (cnt_r == SHW'(1)) begin
            state_r <= ST_FIN;
          end
        end
        ST_FIN: begin
          result  <= acc_r;
          out_O   <= o_r;
          out_S   <= acc_r[WIDTH-1];
          out_C   <= c_r;
          out_Z   <= (acc_r == {WIDTH{1'b0}});
          w_rf    <= wrf_r;
          done    <= 1'b1;
          ready   <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed table-driven bench for alu_seq plus hand sequences for busy, back-to-back and reset cases.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        ready, done, out_O, out_S, out_C, out_Z;
  logic [15:0] result;
  logic [2:0]  w_rf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] res;
    logic [3:0]  oscz;
    logic [2:0]  wrf;
  } vec_t;

  vec_t vq[$];

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result),
    .out_O(out_O), .out_S(out_S), .out_C(out_C), .out_Z(out_Z), .w_rf(w_rf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait for done after the accepting edge, returning edges elapsed (41 on timeout)
  task automatic wait_done(input int already, output int cyc);
    cyc = already;
    while (cyc <= 40 && done !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("v%0d_busy", idx), {31'd0, ready}, 32'd0);
    wait_done(0, cyc);
    chk($sformatf("v%0d_lat", idx), cyc, v.lat);
    chk($sformatf("v%0d_res", idx), {16'd0, result}, {16'd0, v.res});
    chk($sformatf("v%0d_oscz", idx), {28'd0, out_O, out_S, out_C, out_Z}, {28'd0, v.oscz});
    chk($sformatf("v%0d_wrf", idx), {29'd0, w_rf}, {29'd0, v.wrf});
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse", idx), {31'd0, done}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int ndone;
    vq.push_back('{OP_ADD,  16'h7FFF, 16'h0001, 1,  16'h8000, 4'b1100, 3'b100});
    vq.push_back('{OP_SUB,  16'h0005, 16'h0005, 1,  16'h0000, 4'b0011, 3'b100});
    vq.push_back('{OP_SRL,  16'h0003, 16'h0002, 2,  16'h0000, 4'b0011, 3'b011});
    vq.push_back('{OP_SRL,  16'h0003, 16'h0000, 1,  16'h0003, 4'b0000, 3'b011});
    vq.push_back('{OP_MUL,  16'h0100, 16'h0101, 16, 16'h0100, 4'b0000, 3'b010});
    vq.push_back('{OP_ADD,  16'hFFFF, 16'h0001, 1,  16'h0000, 4'b0011, 3'b100});
    vq.push_back('{OP_SUB,  16'h0000, 16'h0001, 1,  16'hFFFF, 4'b0100, 3'b100});
    vq.push_back('{OP_SUB,  16'h8000, 16'h0001, 1,  16'h7FFF, 4'b1010, 3'b100});
    vq.push_back('{OP_INC,  16'h7FFF, 16'h1234, 1,  16'h8000, 4'b1100, 3'b100});
    vq.push_back('{OP_DEC,  16'h0000, 16'h5555, 1,  16'hFFFF, 4'b0100, 3'b100});
    vq.push_back('{OP_AND,  16'hF0F0, 16'h3C3C, 1,  16'h3030, 4'b0000, 3'b010});
    vq.push_back('{OP_OR,   16'h8000, 16'h0001, 1,  16'h8001, 4'b0100, 3'b010});
    vq.push_back('{OP_XOR,  16'hAAAA, 16'hAAAA, 1,  16'h0000, 4'b0001, 3'b010});
    vq.push_back('{OP_NOT,  16'h00FF, 16'h1111, 1,  16'hFF00, 4'b0100, 3'b010});
    vq.push_back('{OP_SLL,  16'h8001, 16'h0001, 1,  16'h0002, 4'b0010, 3'b011});
    vq.push_back('{OP_SRA,  16'h8004, 16'h0003, 3,  16'hF000, 4'b0110, 3'b011});
    vq.push_back('{OP_SLL,  16'h0001, 16'h000F, 15, 16'h8000, 4'b0100, 3'b011});
    vq.push_back('{OP_SRA,  16'h7FFF, 16'h0014, 4,  16'h07FF, 4'b0010, 3'b011});
    vq.push_back('{OP_MUL,  16'h00FF, 16'h00FF, 16, 16'hFE01, 4'b0100, 3'b010});
    vq.push_back('{OP_MUL,  16'hFFFF, 16'hFFFF, 16, 16'h0001, 4'b0000, 3'b010});
    vq.push_back('{OP_MUL,  16'h1234, 16'h0000, 16, 16'h0000, 4'b0001, 3'b010});
    vq.push_back('{OP_CMPZ, 16'h0000, 16'h0000, 1,  16'h0000, 4'b0001, 3'b001});
    vq.push_back('{OP_CMPZ, 16'h0001, 16'h0000, 1,  16'h0001, 4'b0000, 3'b001});
    vq.push_back('{OP_PASS, 16'h8000, 16'h7777, 1,  16'h8000, 4'b0100, 3'b000});
    vq.push_back('{4'hF,    16'h1234, 16'h4321, 1,  16'h1234, 4'b0000, 3'b000});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, out_O, out_S, out_C, out_Z}, 32'd0);
    chk("rst_wrf", {29'd0, w_rf}, 32'd0);

    foreach (vq[i]) run_vec(i, vq[i]);

    // MUL with operand changes and a stray start while busy
    @(negedge clk);
    op = OP_MUL; a = 16'h0100; b = 16'h0101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = OP_ADD; a = 16'hFFFF; b = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    chk("busy_ready", {31'd0, ready}, 32'd0);
    chk("busy_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    wait_done(4, cyc);
    chk("busy_lat", cyc, 16);
    chk("busy_res", {16'd0, result}, 32'h0100);
    chk("busy_wrf", {29'd0, w_rf}, 32'd2);
    ndone = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("busy_no_extra", ndone, 0);

    // Back-to-back with start held high
    @(negedge clk);
    op = OP_AND; a = 16'hFF0F; b = 16'h0FF0; start = 1'b1;
    @(posedge clk); #1;
    op = OP_CMPZ; a = 16'h0000; b = 16'h0000;
    @(posedge clk); #1;
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_res1", {16'd0, result}, 32'h0F00);
    chk("b2b_wrf1", {29'd0, w_rf}, 32'd2);
    @(posedge clk); #1;
    chk("b2b_gap", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_z2", {31'd0, out_Z}, 32'd1);
    chk("b2b_wrf2", {29'd0, w_rf}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_end", {31'd0, done}, 32'd0);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = OP_MUL; a = 16'h00FF; b = 16'h00FF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_ready2", {31'd0, ready}, 32'd1);
    chk("midrst_result", {16'd0, result}, 32'd0);
    chk("midrst_wrf", {29'd0, w_rf}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
